// File: rtl/galaksija_tape_saver_pkg.sv
// Shared types and default timing for the Galaksija cassette recorder.
package galaksija_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    BIT_WIN,
    BIT_GAP,
    DONE
  } tape_state_t;

  // Defaults in clk_sys cycles at 6.25 MHz
  localparam int TAPE_WIN      = 1000;
  localparam int TAPE_IDLE_GAP = 62500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/galaksija_tape_saver_ram.sv
// Byte-wide single-port buffer with registered read, inferred as block RAM.
module tape_buf_ram #(
  parameter int AW = 13
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk_sys) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/galaksija_tape_saver.sv
// Decodes the cassette pulse train into bytes and serves them to the HPS upload port.
module galaksija_tape_saver
  import galaksija_pkg::*;
#(
  parameter int AW       = 13,
  parameter int WIN      = TAPE_WIN,
  parameter int IDLE_GAP = TAPE_IDLE_GAP
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cas_out,
  input  logic          rec_arm,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [26:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic [AW:0]   rec_len,
  output logic          recording,
  output logic          overflow
);

  localparam int CNT_MAX = max_int(WIN, IDLE_GAP);
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_GAP - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [AW:0]   FULL      = {1'b1, {AW{1'b0}}};

  tape_state_t   state;
  logic          cas_q;
  logic          upload_q;
  logic [CW-1:0] cnt;
  logic          bitval;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          rd_hit_q;
  logic [7:0]    ram_q;

  logic          rise;
  logic          is_rec;
  logic          upload_rise;
  logic          cell_end;
  logic [7:0]    shreg_next;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] cnt_inc;

  assign rise        = cas_out & ~cas_q;
  assign is_rec      = (state == ARMED) || (state == BIT_WIN) || (state == BIT_GAP);
  assign upload_rise = ioctl_upload & ~upload_q;
  assign cell_end    = (state == BIT_WIN) && (cnt == WIN_LAST);
  // A rise landing on the last window cycle still counts toward this cell
  assign shreg_next  = {bitval | rise, shreg[7:1]};
  assign cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  // Arm and forced stop both take priority over a byte landing that cycle
  assign ram_we   = cell_end && (bitcnt == 3'd7) && (rec_len != FULL)
                    && !rec_arm && !(upload_rise && is_rec);
  assign ram_re   = ioctl_upload & ioctl_rd & ~ram_we;
  assign ram_addr = ram_we ? rec_len[AW-1:0] : ioctl_addr[AW-1:0];

  tape_buf_ram #(.AW(AW)) u_buf (
    .clk_sys (clk_sys),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (shreg_next),
    .rdata   (ram_q)
  );

  assign ioctl_din = rd_hit_q ? ram_q : 8'h00;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      recording <= 1'b0;
      rec_len   <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
      bitval    <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      cas_q     <= 1'b0;
      upload_q  <= 1'b0;
      rd_hit_q  <= 1'b0;
    end else begin
      cas_q    <= cas_out;
      upload_q <= ioctl_upload;
      if (ram_re)
        rd_hit_q <= (ioctl_addr < 27'(rec_len));

      if (rec_arm) begin
        state     <= ARMED;
        recording <= 1'b1;
        rec_len   <= '0;
        overflow  <= 1'b0;
        bitcnt    <= '0;
        bitval    <= 1'b0;
        cnt       <= '0;
      end else if (upload_rise && is_rec) begin
        state     <= DONE;
        recording <= 1'b0;
        bitcnt    <= '0;
        bitval    <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          ARMED: begin
            if (rise) begin
              state  <= BIT_WIN;
              cnt    <= '0;
              bitval <= 1'b0;
            end
          end
          BIT_WIN: begin
            if (cnt == WIN_LAST) begin
              shreg  <= shreg_next;
              bitval <= 1'b0;
              cnt    <= '0;
              state  <= BIT_GAP;
              if (bitcnt == 3'd7) begin
                bitcnt <= '0;
                if (rec_len != FULL)
                  rec_len <= rec_len + 1'b1;
                else
                  overflow <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
              if (rise)
                bitval <= 1'b1;
            end
          end
          BIT_GAP: begin
            if (rise) begin
              state <= BIT_WIN;
              cnt   <= '0;
            end else if (cnt == GAP_LAST) begin
              state     <= DONE;
              recording <= 1'b0;
              bitcnt    <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_galaksija_tape_saver.sv
// Randomized bench: bytes encoded as pulse cells, compared against a byte-queue model.
module tb_galaksija_tape_saver;

  localparam int AW   = 4;
  localparam int WIN  = 8;
  localparam int GAP  = 32;
  localparam int DEPTH = 2 ** AW;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          cas_out = 1'b0;
  logic          rec_arm = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [26:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_din;
  logic [AW:0]   rec_len;
  logic          recording;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  byte unsigned exp_q[$];
  bit           exp_ovf;

  always #5 clk_sys = ~clk_sys;

  galaksija_tape_saver #(.AW(AW), .WIN(WIN), .IDLE_GAP(GAP)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cas_out      (cas_out),
    .rec_arm      (rec_arm),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .rec_len      (rec_len),
    .recording    (recording),
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One bit cell: opening rise, plus a second rise inside the window for a 1
  task automatic send_bit(input bit b, input bit triple);
    int len;
    int j;
    len = 10 + $urandom_range(0, 6);
    j   = $urandom_range(2, 7);
    for (int i = 0; i < len; i++) begin
      if (i == 0)
        cas_out = 1'b1;
      else if (triple)
        cas_out = (i == 2 || i == 5);
      else
        cas_out = b && (i == j);
      tick();
    end
    cas_out = 1'b0;
  endtask

  task automatic model_push(input byte unsigned v);
    if (exp_q.size() < DEPTH)
      exp_q.push_back(v);
    else
      exp_ovf = 1'b1;
  endtask

  task automatic send_byte(input byte unsigned v);
    for (int i = 0; i < 8; i++)
      send_bit(v[i], 1'b0);
    model_push(v);
    $display("tx byte %02h", v);
  endtask

  task automatic arm();
    rec_arm = 1'b1;
    tick();
    rec_arm = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    cas_out = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_read(input int addr, output logic [7:0] d);
    ioctl_upload = 1'b1;
    ioctl_addr   = 27'(addr);
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
    d            = ioctl_din;
  endtask

  function automatic logic [7:0] exp_byte(input int addr);
    return (addr < exp_q.size()) ? exp_q[addr] : 8'h00;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 4;
    if (ioctl_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", ioctl_din); end
    if (rec_len !== '0) begin failures++; $display("FAIL reset_len got=%0d exp=0", rec_len); end
    if (recording !== 1'b0) begin failures++; $display("FAIL reset_rec got=%b exp=0", recording); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    $display("reset checked");
  endtask

  task automatic test_byte_a5();
    logic [7:0] d;
    arm();
    checks++;
    if (recording !== 1'b1) begin failures++; $display("FAIL a5_armed got=%b exp=1", recording); end
    send_byte(8'hA5);
    idle(40);
    checks += 3;
    if (rec_len !== 5'(exp_q.size())) begin failures++; $display("FAIL a5_len got=%0d exp=%0d", rec_len, exp_q.size()); end
    if (recording !== 1'b0) begin failures++; $display("FAIL a5_done got=%b exp=0", recording); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL a5_ovf got=%b exp=0", overflow); end
    do_read(0, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL a5_read got=%h exp=a5", d); end
    tick();
    checks++;
    if (ioctl_din !== 8'hA5) begin failures++; $display("FAIL a5_hold got=%h exp=a5", ioctl_din); end
    ioctl_upload = 1'b0;
    tick();
    $display("byte A5 len=%0d read=%h", rec_len, d);
  endtask

  task automatic test_partial();
    logic [7:0] d;
    arm();
    send_byte(8'h01);
    send_byte(8'hFF);
    for (int i = 0; i < 3; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b0);
    idle(45);
    checks += 2;
    if (rec_len !== 5'(exp_q.size())) begin failures++; $display("FAIL partial_len got=%0d exp=%0d", rec_len, exp_q.size()); end
    if (recording !== 1'b0) begin failures++; $display("FAIL partial_done got=%b exp=0", recording); end
    for (int a = 0; a < 3; a++) begin
      do_read(a, d);
      checks++;
      if (d !== exp_byte(a)) begin failures++; $display("FAIL partial_read%0d got=%h exp=%h", a, d, exp_byte(a)); end
    end
    ioctl_upload = 1'b0;
    tick();
    $display("partial len=%0d", rec_len);
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int a;
    arm();
    for (int i = 0; i < DEPTH + 1; i++)
      send_byte(8'h5A);
    idle(45);
    checks += 2;
    if (rec_len !== 5'(DEPTH)) begin failures++; $display("FAIL ovf_len got=%0d exp=%0d", rec_len, DEPTH); end
    if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
    do_read(DEPTH - 1, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL ovf_read15 got=%h exp=5a", d); end
    a = $urandom_range(0, DEPTH - 2);
    do_read(a, d);
    checks++;
    if (d !== exp_byte(a)) begin failures++; $display("FAIL ovf_read%0d got=%h exp=%h", a, d, exp_byte(a)); end
    ioctl_upload = 1'b0;
    tick();
    $display("overflow len=%0d ovf=%b", rec_len, overflow);
  endtask

  task automatic test_random();
    logic [7:0] d;
    int n;
    for (int r = 0; r < 3; r++) begin
      arm();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        send_byte(8'($urandom));
      idle(45);
      checks += 2;
      if (rec_len !== 5'(exp_q.size())) begin failures++; $display("FAIL rnd_len got=%0d exp=%0d", rec_len, exp_q.size()); end
      if (overflow !== 1'b0) begin failures++; $display("FAIL rnd_ovf got=%b exp=0", overflow); end
      for (int a = 0; a <= n; a++) begin
        do_read(a, d);
        checks++;
        if (d !== exp_byte(a)) begin failures++; $display("FAIL rnd_read%0d got=%h exp=%h", a, d, exp_byte(a)); end
      end
      ioctl_upload = 1'b0;
      tick();
      $display("random run %0d bytes=%0d", r, n);
    end
  endtask

  task automatic test_upload_mid();
    logic [7:0] d;
    byte unsigned v;
    arm();
    v = 8'($urandom);
    send_byte(v);
    for (int i = 0; i < 4; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b0);
    ioctl_upload = 1'b1;
    tick();
    checks += 2;
    if (recording !== 1'b0) begin failures++; $display("FAIL upmid_rec got=%b exp=0", recording); end
    if (rec_len !== 5'd1) begin failures++; $display("FAIL upmid_len got=%0d exp=1", rec_len); end
    do_read(0, d);
    checks++;
    if (d !== v) begin failures++; $display("FAIL upmid_read got=%h exp=%h", d, v); end
    ioctl_upload = 1'b0;
    tick();
    $display("upload mid-recording byte0=%h", d);
  endtask

  task automatic test_rearm_reset();
    logic [7:0] d;
    arm();
    send_byte(8'h3C);
    send_bit(1'b1, 1'b0);
    checks++;
    if (rec_len !== 5'd1) begin failures++; $display("FAIL rearm_pre got=%0d exp=1", rec_len); end
    arm();
    checks += 2;
    if (rec_len !== 5'd0) begin failures++; $display("FAIL rearm_len got=%0d exp=0", rec_len); end
    if (recording !== 1'b1) begin failures++; $display("FAIL rearm_rec got=%b exp=1", recording); end
    send_byte(8'hC3);
    idle(45);
    do_read(0, d);
    checks++;
    if (d !== 8'hC3) begin failures++; $display("FAIL rearm_read got=%h exp=c3", d); end
    ioctl_upload = 1'b0;
    arm();
    cas_out = 1'b1;
    tick();
    cas_out = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 4;
    if (ioctl_din !== 8'h00) begin failures++; $display("FAIL rst_din got=%h exp=00", ioctl_din); end
    if (rec_len !== '0) begin failures++; $display("FAIL rst_len got=%0d exp=0", rec_len); end
    if (recording !== 1'b0) begin failures++; $display("FAIL rst_rec got=%b exp=0", recording); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    cas_out = 1'b1;
    tick();
    cas_out = 1'b0;
    tick();
    checks++;
    if (recording !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b exp=0", recording); end
    $display("rearm and reset done");
  endtask

  task automatic test_triple();
    logic [7:0] d;
    byte unsigned v;
    byte unsigned w;
    arm();
    v = 8'($urandom) | 8'h01;
    send_bit(1'b1, 1'b1);
    for (int i = 1; i < 8; i++)
      send_bit(v[i], 1'b0);
    model_push(v);
    w = 8'($urandom);
    send_byte(w);
    idle(45);
    checks++;
    if (rec_len !== 5'd2) begin failures++; $display("FAIL triple_len got=%0d exp=2", rec_len); end
    for (int a = 0; a < 2; a++) begin
      do_read(a, d);
      checks++;
      if (d !== exp_byte(a)) begin failures++; $display("FAIL triple_read%0d got=%h exp=%h", a, d, exp_byte(a)); end
    end
    ioctl_upload = 1'b0;
    tick();
    $display("triple pulse bytes %h %h", v, w);
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_partial();
    test_overflow();
    test_random();
    test_upload_mid();
    test_rearm_reset();
    test_triple();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
